store_checker: RTL and testbench

STORE_CHECKER -- requirements
Module: store_checker

---
 rtl/store_checker_pkg.sv | 22 ++
 rtl/store_checker_if.sv | 13 +
 rtl/store_log_fifo.sv | 60 ++++++
 rtl/store_checker.sv | 93 +++++++++
 tb/tb_store_checker.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/store_checker_pkg.sv
// store_checker_pkg: shared types and constants for the store checker.
//   state_t      - checker FSM states
//   log_entry_t  - one 64-bit store log entry {adr, data}
//   DEF_PASS_*   - default pass address / pass data
package store_checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } log_entry_t;

  localparam logic [31:0] DEF_PASS_ADR  = 32'h0000_0054;
  localparam logic [31:0] DEF_PASS_DATA = 32'hffff_7f02;

endpackage

// File: rtl/store_checker_if.sv
// store_checker_if: processor store bus observed by the checker.
//   memwrite  - store strobe
//   dataadr   - store byte address
//   writedata - store data
// master = processor side (drives), slave = checker side (observes).
interface store_checker_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/store_log_fifo.sv
// store_log_fifo: circular log of accepted stores, oldest entry first.
//   clk, reset  - clock, async active-low reset (pointers/count only)
//   push        - write push_entry this edge
//   pop         - drop oldest entry (ignored when empty)
//   valid       - log non-empty
//   head        - oldest entry, combinational from storage
//   overflow    - sticky: an entry was overwritten by a push into a full log
module store_log_fifo
  import store_checker_pkg::*;
#(
  parameter int LOG_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  log_entry_t push_entry,
  input  logic       pop,
  output logic       valid,
  output log_entry_t head,
  output logic       overflow
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(LOG_DEPTH);

  log_entry_t    mem [LOG_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;
  logic          full, do_pop;

  assign full   = (count == FULL_CNT);
  assign do_pop = pop && (count != '0);
  assign valid  = (count != '0);
  assign head   = mem[rptr];

  // storage is not reset; only pointers and count define contents
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      // read pointer advances on a real pop, or when a push overwrites the oldest
      if (do_pop || (push && full)) rptr <= rptr + PW'(1);
      if (push && !do_pop) begin
        if (full) overflow <= 1'b1;
        else      count    <= count + (PW+1)'(1);
      end else if (!push && do_pop) begin
        count <= count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/store_checker.sv
// store_checker: watches processor stores and decides pass/fail/timeout.
//   clk, reset    - clock, async active-low reset
//   bus           - store bus (memwrite, dataadr, writedata)
//   log_pop       - consumer pops oldest log entry
//   done          - in any terminal state
//   pass/fail/timeout - one-hot terminal flags
//   store_count   - accepted stores, saturating
//   log_valid, log_adr, log_data - oldest log entry
//   log_overflow  - sticky log overwrite flag
module store_checker
  import store_checker_pkg::*;
#(
  parameter logic [31:0] PASS_ADR  = DEF_PASS_ADR,
  parameter logic [31:0] PASS_DATA = DEF_PASS_DATA,
  parameter int          STRICT    = 1,
  parameter int          TIMEOUT   = 1000,
  parameter int          LOG_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  store_checker_if.slave        bus,
  input  logic                  log_pop,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [15:0]           store_count,
  output logic                  log_valid,
  output logic [31:0]           log_adr,
  output logic [31:0]           log_data,
  output logic                  log_overflow
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cyc;
  logic          accept;
  log_entry_t    push_entry, head;

  assign accept     = bus.memwrite && (state == ST_RUN);
  assign push_entry = '{adr: bus.dataadr, data: bus.writedata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nx;
  end

  // a terminal store wins over the timeout on the same edge
  always_comb begin
    state_nx = state;
    if (state == ST_RUN) begin
      if (accept && bus.dataadr == PASS_ADR)
        state_nx = (bus.writedata == PASS_DATA) ? ST_PASS : ST_FAIL;
      else if (accept && STRICT != 0)
        state_nx = ST_FAIL;
      else if (cyc == CYC_LAST)
        state_nx = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc         <= '0;
      store_count <= '0;
    end else begin
      if (state == ST_RUN && cyc != CYC_LAST) cyc <= cyc + CW'(1);
      if (accept && store_count != 16'hffff)  store_count <= store_count + 16'd1;
    end
  end

  // flags decode straight from the state register, so they are registered
  assign done    = (state != ST_RUN);
  assign pass    = (state == ST_PASS);
  assign fail    = (state == ST_FAIL);
  assign timeout = (state == ST_TIMEOUT);

  store_log_fifo #(.LOG_DEPTH(LOG_DEPTH)) u_log (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (log_pop),
    .valid      (log_valid),
    .head       (head),
    .overflow   (log_overflow)
  );

  assign log_adr  = head.adr;
  assign log_data = head.data;

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: self-checking bench for store_checker.
// dut0 runs STRICT=0 with a log scoreboard; dut1 runs STRICT=1.
module tb_store_checker;
  import store_checker_pkg::*;

  localparam logic [31:0] PD = 32'hffff7f02;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  store_checker_if bus0 ();
  store_checker_if bus1 ();

  logic        pop0, pop1;
  logic        done0, pass0, fail0, tmo0, lv0, ovf0;
  logic        done1, pass1, fail1, tmo1, lv1, ovf1;
  logic [15:0] cnt0, cnt1;
  logic [31:0] ladr0, ldat0, ladr1, ldat1;

  store_checker #(.STRICT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .log_pop(pop0),
    .done(done0), .pass(pass0), .fail(fail0), .timeout(tmo0),
    .store_count(cnt0), .log_valid(lv0), .log_adr(ladr0),
    .log_data(ldat0), .log_overflow(ovf0));

  store_checker #(.STRICT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .log_pop(pop1),
    .done(done1), .pass(pass1), .fail(fail1), .timeout(tmo1),
    .store_count(cnt1), .log_valid(lv1), .log_adr(ladr1),
    .log_data(ldat1), .log_overflow(ovf1));

  int checks   = 0;
  int failures = 0;

  // scoreboard of dut0 log contents, oldest first
  log_entry_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    exp_q.delete();
    reset = 1'b1;
  endtask

  // one store on the next posedge; live = dut0 expected to accept it
  task automatic store(input int sel, input logic [31:0] adr, input logic [31:0] data,
                       input bit live);
    @(negedge clk);
    if (sel == 0) begin
      bus0.memwrite = 1'b1; bus0.dataadr = adr; bus0.writedata = data;
      if (live) begin
        exp_q.push_back('{adr: adr, data: data});
        if (exp_q.size() > 4) void'(exp_q.pop_front());
      end
    end else begin
      bus1.memwrite = 1'b1; bus1.dataadr = adr; bus1.writedata = data;
    end
    @(negedge clk);
    bus0.memwrite = 1'b0;
    bus1.memwrite = 1'b0;
  endtask

  // pop dut0 log, comparing head against the scoreboard
  task automatic pop_chk(input string tag);
    log_entry_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, 64'(lv0), 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 64'(lv0), 64'd1);
      chk({tag, "_entry"}, {ladr0, ldat0}, {e.adr, e.data});
    end
    pop0 = 1'b1;
    @(negedge clk);
    pop0 = 1'b0;
  endtask

  // push and pop dut0 on the same edge
  task automatic push_pop(input logic [31:0] adr, input logic [31:0] data);
    log_entry_t e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pp_head", {ladr0, ldat0}, {e.adr, e.data});
    end
    exp_q.push_back('{adr: adr, data: data});
    bus0.memwrite = 1'b1; bus0.dataadr = adr; bus0.writedata = data;
    pop0 = 1'b1;
    @(negedge clk);
    bus0.memwrite = 1'b0;
    pop0 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) pop_chk(tag);
    @(negedge clk);
    chk({tag, "_drained"}, 64'(lv0), 64'd0);
  endtask

  initial begin
    bus0.memwrite = 1'b0; bus0.dataadr = '0; bus0.writedata = '0;
    bus1.memwrite = 1'b0; bus1.dataadr = '0; bus1.writedata = '0;
    pop0 = 1'b0; pop1 = 1'b0;

    // reset state
    #3;
    chk("rst_flags0", {done0, pass0, fail0, tmo0, lv0, ovf0}, 6'b0);
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    chk("rst_flags1", {done1, pass1, fail1, tmo1, lv1, ovf1}, 6'b0);
    do_reset();

    // non-strict: other address logged, then pass
    store(0, 32'h50, 32'h7, 1'b1);
    chk("ns_run", {done0, pass0, fail0}, 3'b000);
    chk("ns_cnt1", 64'(cnt0), 64'd1);
    store(0, 32'h54, PD, 1'b1);
    chk("ns_pass", {done0, pass0, fail0, tmo0}, 4'b1100);
    chk("ns_cnt2", 64'(cnt0), 64'd2);
    store(0, 32'h60, 32'h1, 1'b0);
    chk("ns_absorb_cnt", 64'(cnt0), 64'd2);
    drain("ns_log");

    // strict: other address fails, later pass store ignored
    do_reset();
    store(1, 32'h50, 32'h7, 1'b0);
    chk("st_fail", {done1, pass1, fail1}, 3'b101);
    chk("st_cnt", 64'(cnt1), 64'd1);
    store(1, 32'h54, PD, 1'b0);
    chk("st_absorb", {pass1, fail1}, 2'b01);
    chk("st_absorb_cnt", 64'(cnt1), 64'd1);

    // wrong data at the pass address
    do_reset();
    store(1, 32'h54, 32'h7, 1'b0);
    chk("wd_fail", {done1, fail1, pass1}, 3'b110);
    chk("wd_log", {ladr1, ldat1}, {32'h54, 32'h7});

    // overflow: six stores into a depth-4 log
    do_reset();
    for (int i = 0; i < 6; i++) store(0, 32'h100 + 32'(i * 4), 32'(i + 10), 1'b1);
    chk("ov_flag", 64'(ovf0), 64'd1);
    chk("ov_oldest", {ladr0, ldat0}, {32'h108, 32'd12});
    drain("ov_log");

    // push+pop while full: no overflow, count stays 4
    do_reset();
    for (int i = 0; i < 4; i++) store(0, 32'h200 + 32'(i * 4), 32'(i), 1'b1);
    chk("full_noovf", 64'(ovf0), 64'd0);
    push_pop(32'h300, 32'h33);
    chk("pp_noovf", 64'(ovf0), 64'd0);
    drain("pp_log");

    // push+pop while empty keeps the pushed entry
    push_pop(32'h400, 32'h44);
    chk("pe_valid", 64'(lv0), 64'd1);
    drain("pe_log");

    // timeout after exactly 1000 RUN edges
    do_reset();
    repeat (999) @(posedge clk);
    #1 chk("tmo_pre", 64'(tmo1), 64'd0);
    @(posedge clk);
    #1 chk("tmo_hit", {done1, tmo1, pass1, fail1}, 4'b1100);

    // pass store on the final RUN edge wins over timeout
    do_reset();
    repeat (999) @(posedge clk);
    #1;
    bus1.memwrite = 1'b1; bus1.dataadr = 32'h54; bus1.writedata = PD;
    @(posedge clk);
    #1;
    bus1.memwrite = 1'b0;
    chk("tmo_prio", {done1, pass1, tmo1}, 3'b110);
    chk("tmo_prio_cnt", 64'(cnt1), 64'd1);

    // async reset mid-cycle while in PASS
    do_reset();
    store(0, 32'h54, PD, 1'b1);
    chk("ar_pass", 64'(pass0), 64'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ar_clear", {done0, pass0, fail0, tmo0, lv0, ovf0}, 6'b0);
    chk("ar_cnt", 64'(cnt0), 64'd0);
    exp_q.delete();
    #1 reset = 1'b1;
    store(0, 32'h54, PD, 1'b1);
    chk("ar_repass", {done0, pass0}, 2'b11);
    chk("ar_recnt", 64'(cnt0), 64'd1);
    drain("ar_log");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
